// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_fetch_pkg;
  // Widest PC the fetch entry can carry; narrower cores zero-extend into it.
  localparam int PKG_DW = 64;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PKG_DW-1:0] pc;
    logic [31:0]       instr;
  } fetch_entry_t;
endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with flush; flush beats push/pop in the same cycle.
// Storage is reset so the head word is never X while the FIFO is empty.
module rv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_dout,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_count;

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage; a flush only moves pointers, stale words are unreachable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !i_flush) begin
      r_mem[r_wr] <= i_din;
    end
  end

  assign o_dout  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/rv_fetch_unit.sv
// IF stage: owns the PC, issues one sequential fetch per cycle to a 1-cycle
// instruction memory, buffers responses and hands {pc, instr} to decode.
// A redirect kills queued entries and the response arriving that cycle.
module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int            DW          = 64,
  parameter int            FETCH_DEPTH = 4,
  parameter logic [DW-1:0] RESET_PC    = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  output logic                           o_imem_req,
  output logic [DW-1:0]                  o_imem_addr,
  input  logic [31:0]                    i_imem_rdata,
  input  logic                           i_redirect_valid,
  input  logic [DW-1:0]                  i_redirect_pc,
  output logic                           o_dec_valid,
  input  logic                           i_dec_ready,
  output logic [DW-1:0]                  o_dec_pc,
  output logic [31:0]                    o_dec_instr,
  output logic [$clog2(FETCH_DEPTH):0]   o_fq_count
);
  localparam int CW = $clog2(FETCH_DEPTH) + 1;

  logic [DW-1:0] r_fetch_pc;
  logic          r_inflight;
  logic [DW-1:0] r_inflight_pc;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_used;
  logic          w_credit;
  logic          w_deq;
  logic          w_issue;
  logic          w_rsp_ok;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  // Credit counts the in-flight word so a response always has a slot.
  assign w_used   = {1'b0, w_count} + (CW+1)'(r_inflight);
  assign w_credit = w_used < (CW+1)'(FETCH_DEPTH);

  assign o_dec_valid = (w_count != '0) & ~i_redirect_valid;
  assign w_deq       = o_dec_valid & i_dec_ready;
  // Reset gates issue combinationally so the request drops without a clock edge.
  assign w_issue     = ~i_rst & ~i_redirect_valid & (w_credit | w_deq);
  assign w_rsp_ok    = r_inflight & ~i_redirect_valid;

  assign o_imem_req  = w_issue;
  assign o_imem_addr = r_fetch_pc;

  assign w_push_entry.pc    = PKG_DW'(r_inflight_pc);
  assign w_push_entry.instr = i_imem_rdata;

  rv_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FETCH_DEPTH)
  ) u_fq (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_rsp_ok),
    .i_din   (w_push_entry),
    .i_pop   (w_deq),
    .i_flush (i_redirect_valid),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  assign o_dec_pc    = w_head.pc[DW-1:0];
  assign o_dec_instr = w_head.instr;
  assign o_fq_count  = w_count;

  // PC advance / redirect, plus tracking of the outstanding request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_fetch_pc;
      if (i_redirect_valid)
        r_fetch_pc <= {i_redirect_pc[DW-1:2], 2'b00};
      else if (w_issue)
        r_fetch_pc <= r_fetch_pc + DW'(INSTR_BYTES);
    end
  end
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: directed vector table, async reset check, wrap
// check on a 32-bit instance, and a randomized run against a queue model.
module tb_rv_fetch_unit;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // 64-bit instance (default RESET_PC = 0)
  logic        o_imem_req, o_dec_valid, i_redirect_valid, i_dec_ready;
  logic [63:0] o_imem_addr, i_redirect_pc, o_dec_pc;
  logic [31:0] i_imem_rdata, o_dec_instr;
  logic [2:0]  o_fq_count;

  // 32-bit wrap instance
  logic        w_req, w_val, w_redir, w_rdy;
  logic [31:0] w_addr, w_rpc, w_pc, w_rdata, w_instr;
  logic [2:0]  w_cnt;

  rv_fetch_unit #(.DW(64), .FETCH_DEPTH(D)) dut (
    .i_clk(clk), .i_rst(rst), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_rdata(i_imem_rdata), .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc(i_redirect_pc), .o_dec_valid(o_dec_valid), .i_dec_ready(i_dec_ready),
    .o_dec_pc(o_dec_pc), .o_dec_instr(o_dec_instr), .o_fq_count(o_fq_count));

  rv_fetch_unit #(.DW(32), .FETCH_DEPTH(D), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .i_clk(clk), .i_rst(rst), .o_imem_req(w_req), .o_imem_addr(w_addr),
    .i_imem_rdata(w_rdata), .i_redirect_valid(w_redir), .i_redirect_pc(w_rpc),
    .o_dec_valid(w_val), .i_dec_ready(w_rdy), .o_dec_pc(w_pc), .o_dec_instr(w_instr),
    .o_fq_count(w_cnt));

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: fetch PC, one outstanding request, FIFO as a queue.
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  logic [63:0] m_pc, m_infl_pc;
  bit          m_infl;

  task automatic model_reset();
    m_q.delete(); m_pc = '0; m_infl = 0; m_infl_pc = '0;
  endtask

  // Sampled values of the last step
  logic        s_req, s_val, sw_req, sw_val;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_instr, sw_addr, sw_pc;
  logic [2:0]  s_cnt;

  // One clock cycle: drive inputs, sample + model-check mid-cycle, advance.
  task automatic step(input logic rv, input logic [63:0] rp, input logic rdy);
    bit e_val, e_deq, e_iss;
    ent_t e;
    i_redirect_valid = rv; i_redirect_pc = rp; i_dec_ready = rdy;
    @(negedge clk);
    s_req = o_imem_req; s_addr = o_imem_addr; s_val = o_dec_valid;
    s_pc = o_dec_pc; s_instr = o_dec_instr; s_cnt = o_fq_count;
    sw_req = w_req; sw_addr = w_addr; sw_val = w_val; sw_pc = w_pc;
    e_val = (m_q.size() != 0) && !rv;
    e_deq = e_val && rdy;
    e_iss = !rv && (((m_q.size() + int'(m_infl)) < D) || e_deq);
    chk("m_req", s_req, e_iss);
    chk("m_addr", s_addr, m_pc);
    chk("m_dvalid", s_val, e_val);
    chk("m_count", s_cnt, m_q.size());
    if (e_val) begin
      chk("m_dpc", s_pc, m_q[0].pc);
      chk("m_dinstr", s_instr, m_q[0].instr);
    end
    if (rv) m_q.delete();
    else begin
      if (e_deq) void'(m_q.pop_front());
      if (m_infl) begin e.pc = m_infl_pc; e.instr = memf(m_infl_pc); m_q.push_back(e); end
    end
    if (e_iss) m_infl_pc = m_pc;
    m_infl = e_iss;
    if (rv) m_pc = {rp[63:2], 2'b00};
    else if (e_iss) m_pc = m_pc + 64'd4;
    @(posedge clk); #1;
    i_imem_rdata = memf(s_addr);
    w_rdata = memf({32'd0, sw_addr});
  endtask

  typedef struct {
    logic rv; logic [63:0] rp; logic rdy;
    logic req; logic [63:0] addr; logic val; logic [63:0] pc; int cnt;
  } vec_t;
  vec_t tbl[25];

  initial begin
    // stream, backpressure, redirect with fetch in flight, misaligned + back-to-back redirects
    tbl[0]  = '{0, 64'h0,   1, 1, 64'h000, 0, 64'h000, 0};
    tbl[1]  = '{0, 64'h0,   1, 1, 64'h004, 0, 64'h000, 0};
    tbl[2]  = '{0, 64'h0,   1, 1, 64'h008, 1, 64'h000, 1};
    tbl[3]  = '{0, 64'h0,   1, 1, 64'h00C, 1, 64'h004, 1};
    tbl[4]  = '{0, 64'h0,   0, 1, 64'h010, 1, 64'h008, 1};
    tbl[5]  = '{0, 64'h0,   0, 1, 64'h014, 1, 64'h008, 2};
    tbl[6]  = '{0, 64'h0,   0, 0, 64'h018, 1, 64'h008, 3};
    tbl[7]  = '{0, 64'h0,   0, 0, 64'h018, 1, 64'h008, 4};
    tbl[8]  = '{0, 64'h0,   0, 0, 64'h018, 1, 64'h008, 4};
    tbl[9]  = '{0, 64'h0,   1, 1, 64'h018, 1, 64'h008, 4};
    tbl[10] = '{0, 64'h0,   1, 1, 64'h01C, 1, 64'h00C, 3};
    tbl[11] = '{0, 64'h0,   1, 1, 64'h020, 1, 64'h010, 3};
    tbl[12] = '{0, 64'h0,   1, 1, 64'h024, 1, 64'h014, 3};
    tbl[13] = '{0, 64'h0,   1, 1, 64'h028, 1, 64'h018, 3};
    tbl[14] = '{1, 64'h100, 1, 0, 64'h02C, 0, 64'h000, 3};
    tbl[15] = '{0, 64'h0,   1, 1, 64'h100, 0, 64'h000, 0};
    tbl[16] = '{0, 64'h0,   1, 1, 64'h104, 0, 64'h000, 0};
    tbl[17] = '{0, 64'h0,   1, 1, 64'h108, 1, 64'h100, 1};
    tbl[18] = '{1, 64'h103, 1, 0, 64'h10C, 0, 64'h000, 1};
    tbl[19] = '{0, 64'h0,   1, 1, 64'h100, 0, 64'h000, 0};
    tbl[20] = '{1, 64'h200, 1, 0, 64'h104, 0, 64'h000, 0};
    tbl[21] = '{1, 64'h300, 1, 0, 64'h200, 0, 64'h000, 0};
    tbl[22] = '{0, 64'h0,   1, 1, 64'h300, 0, 64'h000, 0};
    tbl[23] = '{0, 64'h0,   1, 1, 64'h304, 0, 64'h000, 0};
    tbl[24] = '{0, 64'h0,   1, 1, 64'h308, 1, 64'h300, 1};

    rst = 1'b1;
    i_redirect_valid = 0; i_redirect_pc = '0; i_dec_ready = 0; i_imem_rdata = '0;
    w_redir = 0; w_rpc = '0; w_rdy = 1; w_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", o_imem_req, 1'b0);
    chk("rst_dvalid", o_dec_valid, 1'b0);
    chk("rst_count", o_fq_count, 3'd0);
    chk("rst_dpc", o_dec_pc, 64'd0);
    chk("rst_dinstr", o_dec_instr, 32'd0);
    model_reset();
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].rv, tbl[i].rp, tbl[i].rdy);
      chk($sformatf("t%0d_req", i), s_req, tbl[i].req);
      chk($sformatf("t%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("t%0d_dvalid", i), s_val, tbl[i].val);
      chk($sformatf("t%0d_count", i), s_cnt, tbl[i].cnt);
      if (tbl[i].val) begin
        chk($sformatf("t%0d_dpc", i), s_pc, tbl[i].pc);
        chk($sformatf("t%0d_dinstr", i), s_instr, memf(tbl[i].pc));
      end
      // 32-bit instance wraps FFFF_FFFC -> 0000_0000
      if (i == 0) chk("wrap_a0", sw_addr, 32'hFFFF_FFFC);
      if (i == 1) chk("wrap_a1", sw_addr, 32'h0000_0000);
      if (i == 2) begin chk("wrap_v2", sw_val, 1'b1); chk("wrap_p2", sw_pc, 32'hFFFF_FFFC); end
      if (i == 3) begin chk("wrap_v3", sw_val, 1'b1); chk("wrap_p3", sw_pc, 32'h0000_0000); end
    end

    // Build up to half full, then reset between clock edges
    step(0, 64'h0, 0);
    chk("pre_rst_count", o_fq_count, 3'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", o_imem_req, 1'b0);
    chk("arst_dvalid", o_dec_valid, 1'b0);
    chk("arst_count", o_fq_count, 3'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    i_imem_rdata = '0;

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic        rv, rdy;
      logic [63:0] rp;
      rv  = ($urandom_range(0, 19) == 0);
      rp  = {$urandom(), $urandom()};
      rdy = ($urandom_range(0, 9) < 6);
      step(rv, rp, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
